// File: rtl/pcecd_cmd_receiver_if.sv
// Handshake and command-result bundle between the SCSI initiator side and the CD command receiver.
// The master side drives the bus inputs; the receiver uses the slave modport.
interface pcecd_cmd_receiver_if;
    logic        i_start;
    logic        i_abort;
    logic        i_ack;
    logic [7:0]  i_db;
    logic        i_cmd_taken;
    logic        o_req;
    logic        o_busy;
    logic        o_cmd_valid;
    logic [7:0]  o_cmd_opcode;
    logic [3:0]  o_cmd_len;
    logic [79:0] o_cmd_bytes;
    logic        o_unsupported;
    logic        o_timeout;

    modport master (
        output i_start, i_abort, i_ack, i_db, i_cmd_taken,
        input  o_req, o_busy, o_cmd_valid, o_cmd_opcode, o_cmd_len,
               o_cmd_bytes, o_unsupported, o_timeout
    );

    modport slave (
        input  i_start, i_abort, i_ack, i_db, i_cmd_taken,
        output o_req, o_busy, o_cmd_valid, o_cmd_opcode, o_cmd_len,
               o_cmd_bytes, o_unsupported, o_timeout
    );
endinterface

// File: rtl/pcecd_cmd_receiver.sv
// Collects a 6- or 10-byte command over the REQ/ACK handshake during COMMAND phase.
// The command length is decided by the opcode group as soon as byte 0 arrives.
module pcecd_cmd_receiver #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pcecd_cmd_receiver_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        ACK_LOW_WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [3:0]       count;
    logic [3:0]       target_len;
    logic [9:0][7:0]  cmd_bytes;
    logic             unsupported;
    logic             timeout_q;
    logic [15:0]      idle_cnt;
    logic             capture;
    logic             timeout_hit;
    logic             idle_limit;
    logic             handshaking;

    function automatic logic opcode_supported(input logic [7:0] op);
        case (op)
            8'h00, 8'h03, 8'h08, 8'hD8,
            8'hD9, 8'hDA, 8'hDD, 8'hDE: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    assign handshaking = (state == REQ_HI) || (state == ACK_LOW_WAIT);
    assign idle_limit  = (idle_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Abort overrides everything, including a handshake or timeout landing in the same cycle.
    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (bus.i_ack) begin
                    state_d = ACK_LOW_WAIT;
                    capture = 1'b1;
                end else if (idle_limit) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ACK_LOW_WAIT: begin
                if (!bus.i_ack) begin
                    state_d = (count < target_len) ? REQ_HI : DONE;
                end else if (idle_limit) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (bus.i_cmd_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.i_abort) begin
            state_d     = IDLE;
            capture     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // Captured bytes survive an abort so the last partial command can still be inspected.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count       <= 4'd0;
            target_len  <= 4'd0;
            cmd_bytes   <= '0;
            unsupported <= 1'b0;
            timeout_q   <= 1'b0;
            idle_cnt    <= 16'd0;
        end else begin
            timeout_q <= timeout_hit;
            if (!handshaking || (state_d != state)) begin
                idle_cnt <= 16'd0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if ((state == IDLE) && (state_d == REQ_HI)) begin
                count       <= 4'd0;
                target_len  <= 4'd6;
                cmd_bytes   <= '0;
                unsupported <= 1'b0;
            end
            if (capture) begin
                cmd_bytes[count] <= bus.i_db;
                count            <= count + 4'd1;
                if (count == 4'd0) begin
                    target_len  <= (bus.i_db[7:5] == 3'b000) ? 4'd6 : 4'd10;
                    unsupported <= !opcode_supported(bus.i_db);
                end
            end
        end
    end

    assign bus.o_req         = (state == REQ_HI);
    assign bus.o_busy        = (state != IDLE);
    assign bus.o_cmd_valid   = (state == DONE);
    assign bus.o_cmd_opcode  = cmd_bytes[0];
    assign bus.o_cmd_len     = count;
    assign bus.o_cmd_bytes   = cmd_bytes;
    assign bus.o_unsupported = unsupported;
    assign bus.o_timeout     = timeout_q;

endmodule

// File: tb/tb_pcecd_cmd_receiver.sv
// Directed bench for the command receiver: expected commands go into a scoreboard queue
// and a negedge monitor pops one each time o_cmd_valid rises.
module tb_pcecd_cmd_receiver;

    typedef struct {
        logic [3:0]  len;
        logic        unsup;
        logic [79:0] bytes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   req_rises   = 0;
    logic prev_req    = 1'b0;
    logic prev_valid  = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pcecd_cmd_receiver_if bus();

    pcecd_cmd_receiver #(.TIMEOUT_CYCLES(16'd16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each rising edge of o_cmd_valid must match the oldest queued command.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.o_req && !prev_req) req_rises++;
        prev_req = bus.o_req;
        if (bus.o_cmd_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_cmd_valid", 80'(1'b1), 80'(1'b0));
            end else begin
                e = sb.pop_front();
                checkOutput("cmd_len", 80'(bus.o_cmd_len), 80'(e.len));
                checkOutput("cmd_opcode", 80'(bus.o_cmd_opcode), 80'(e.bytes[7:0]));
                checkOutput("cmd_unsupported", 80'(bus.o_unsupported), 80'(e.unsup));
                checkOutput("cmd_bytes", bus.o_cmd_bytes, e.bytes);
            end
        end
        prev_valid = bus.o_cmd_valid;
    end

    task automatic pulseStart();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t;
        t = 0;
        while (!bus.o_req && t < 12) begin
            @(negedge clk);
            t++;
        end
        if (!bus.o_req) checkOutput("req_wait_expired", 80'(1'b0), 80'(1'b1));
        bus.i_db  = b;
        bus.i_ack = 1'b1;
        @(negedge clk);
        t = 0;
        while (bus.o_req && t < 12) begin
            @(negedge clk);
            t++;
        end
        if (bus.o_req) checkOutput("req_drop_expired", 80'(1'b1), 80'(1'b0));
        bus.i_ack = 1'b0;
    endtask

    task automatic applyStimulus(input logic [79:0] cmd, input int n, input logic [3:0] exp_len,
                                 input logic exp_unsup, input bit start_in_done);
        exp_t e;
        int   t;
        e.len   = exp_len;
        e.unsup = exp_unsup;
        e.bytes = cmd;
        sb.push_back(e);
        pulseStart();
        for (int i = 0; i < n; i++) sendByte(cmd[8*i +: 8]);
        t = 0;
        while (!bus.o_cmd_valid && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!bus.o_cmd_valid) checkOutput("cmd_valid_wait_expired", 80'(1'b0), 80'(1'b1));
        if (start_in_done) begin
            pulseStart();
            @(negedge clk);
            checkOutput("valid_held_after_start_in_done", 80'(bus.o_cmd_valid), 80'(1'b1));
            checkOutput("len_held_after_start_in_done", 80'(bus.o_cmd_len), 80'(exp_len));
        end
        bus.i_cmd_taken = 1'b1;
        @(negedge clk);
        bus.i_cmd_taken = 1'b0;
        checkOutput("valid_cleared_after_taken", 80'(bus.o_cmd_valid), 80'(1'b0));
        checkOutput("idle_after_taken", 80'(bus.o_busy), 80'(1'b0));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req"}, 80'(bus.o_req), 80'(1'b0));
        checkOutput({tag, "_busy"}, 80'(bus.o_busy), 80'(1'b0));
        checkOutput({tag, "_valid"}, 80'(bus.o_cmd_valid), 80'(1'b0));
        checkOutput({tag, "_timeout"}, 80'(bus.o_timeout), 80'(1'b0));
        checkOutput({tag, "_unsup"}, 80'(bus.o_unsupported), 80'(1'b0));
        checkOutput({tag, "_opcode"}, 80'(bus.o_cmd_opcode), 80'h0);
        checkOutput({tag, "_len"}, 80'(bus.o_cmd_len), 80'h0);
        checkOutput({tag, "_bytes"}, bus.o_cmd_bytes, 80'h0);
    endtask

    initial begin : stimulus
        int k;
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_ack       = 1'b0;
        bus.i_db        = 8'h00;
        bus.i_cmd_taken = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetState("reset");

        // TEST UNIT READY, with a stray start while the command is held
        applyStimulus(80'h0, 6, 4'd6, 1'b0, 1'b1);

        // READ SUBCODE Q: ten bytes, REQ must rise exactly ten times
        req_rises = 0;
        applyStimulus(80'h0000_0000_0000_0000_0ADD, 10, 4'd10, 1'b0, 1'b0);
        checkOutput("read_subcode_req_count", 80'(req_rises), 80'd10);

        // Unsupported opcodes in both length groups
        applyStimulus(80'h0504_0302_0112, 6, 4'd6, 1'b1, 1'b0);
        applyStimulus(80'h9988_7766_5544_3322_11C0, 10, 4'd10, 1'b1, 1'b0);

        // Abort after the third byte is acknowledged, with start asserted during abort
        pulseStart();
        sendByte(8'hD8);
        sendByte(8'h01);
        k = 0;
        while (!bus.o_req && k < 12) begin
            @(negedge clk);
            k++;
        end
        bus.i_db  = 8'h02;
        bus.i_ack = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_req", 80'(bus.o_req), 80'(1'b0));
        checkOutput("abort_idle", 80'(bus.o_busy), 80'(1'b0));
        checkOutput("abort_valid", 80'(bus.o_cmd_valid), 80'(1'b0));
        checkOutput("abort_bytes_retained", bus.o_cmd_bytes, 80'h02_01D8);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checkOutput("start_ignored_during_abort", 80'(bus.o_busy), 80'(1'b0));
        bus.i_abort = 1'b0;
        bus.i_ack   = 1'b0;
        @(negedge clk);
        applyStimulus(80'h0908_0706_0504_0302_01D8, 10, 4'd10, 1'b0, 1'b0);

        // Handshake timeout with ACK held low
        pulseStart();
        k = 1;
        while (!bus.o_timeout && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("timeout_latency", 80'(k), 80'd17);
        checkOutput("timeout_busy_cleared", 80'(bus.o_busy), 80'(1'b0));
        checkOutput("timeout_req_low", 80'(bus.o_req), 80'(1'b0));
        @(negedge clk);
        checkOutput("timeout_single_pulse", 80'(bus.o_timeout), 80'(1'b0));

        // Reset in the middle of a command, then a clean REQUEST SENSE
        pulseStart();
        sendByte(8'h03);
        sendByte(8'hAA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetState("midcmd_reset");
        applyStimulus(80'h00_1200_0000_03, 6, 4'd6, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 80'(sb.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/pcecd_cmd_receiver.md
PCECD_CMD_RECEIVER -- requirements
Module: pcecd_cmd_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd50000: handshake inactivity limit in clock cycles.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_start  input  1  one-cycle pulse from the bus-phase controller on entry to COMMAND phase.
REQ-005 i_abort  input  1  bus reset (RST) level; forces return to idle.
REQ-006 i_ack  input  1  initiator ACK level.
REQ-007 i_db  input  8  initiator data bus (DB).
REQ-008 o_req  output  1  target REQ; drives REQ bit (bit 6) of the CDC status register.
REQ-009 o_busy  output  1  high in every state except IDLE.
REQ-010 o_cmd_valid  output  1  complete command held; stays high until taken.
REQ-011 i_cmd_taken  input  1  consumer acknowledge; clears o_cmd_valid.
REQ-012 o_cmd_opcode  output  8  byte 0 of received command.
REQ-013 o_cmd_len  output  4  byte count received: 6 or 10.
REQ-014 o_cmd_bytes  output  80  byte k at bits [8k+7:8k]; unreceived bytes zero.
REQ-015 o_unsupported  output  1  opcode not in supported set; valid with o_cmd_valid.
REQ-016 o_timeout  output  1  one-cycle pulse on handshake timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ_HI, ACK_LOW_WAIT, DONE.
REQ-018 IDLE + i_start: next cycle REQ_HI, o_req=1, byte count=0, o_cmd_bytes cleared to 0, o_unsupported=0.
REQ-019 REQ_HI: o_req=1; on edge where i_ack=1 sampled, i_db captured into byte[count], count+1, next state ACK_LOW_WAIT, o_req=0 next cycle.
REQ-020 ACK_LOW_WAIT: o_req=0; on i_ack=0 sampled, next state REQ_HI if count < target length, else DONE.
REQ-021 Target length fixed at byte-0 capture: opcode[7:5]==3'b000 -> 6, otherwise 10.
REQ-022 Supported opcodes: 00, 03, 08, D8, D9, DA, DD, DE; any other opcode sets o_unsupported at byte-0 capture; reception still completes at the computed length.
REQ-023 DONE: o_cmd_valid=1, o_cmd_len=count, outputs stable; i_cmd_taken=1 -> IDLE next cycle, o_cmd_valid=0.
REQ-024 i_start outside IDLE SHALL be ignored; i_cmd_taken outside DONE SHALL be ignored.
REQ-025 i_ack already high in the cycle REQ_HI is entered SHALL be treated as a valid ACK (level-sampled, not edge).
REQ-026 Inactivity counter resets on every state transition; in REQ_HI or ACK_LOW_WAIT, reaching TIMEOUT_CYCLES -> o_timeout=1 for one cycle, IDLE, o_req=0, no o_cmd_valid.
REQ-027 i_abort=1 in any state SHALL force IDLE next cycle, o_req=0, o_cmd_valid=0, o_cmd_bytes retained; i_abort has priority over i_start, i_ack, i_cmd_taken and timeout.
REQ-028 While i_abort=1, i_start SHALL be ignored.

Reset
REQ-029 i_rst=1 SHALL set state IDLE, o_req=0, o_busy=0, o_cmd_valid=0, o_timeout=0, o_unsupported=0, o_cmd_opcode=0, o_cmd_len=0, o_cmd_bytes=0, counters=0; i_rst has priority over all inputs.

Verification
REQ-030 TEST UNIT READY: i_start, six handshakes with DB=00 -> o_cmd_valid=1, o_cmd_len=6, o_cmd_opcode=8'h00, o_unsupported=0, o_cmd_bytes=0.
REQ-031 READ SUBCODE Q: DB=DD,0A,00,00,00,00,00,00,00,00 -> o_cmd_len=10, o_cmd_bytes[7:0]=8'hDD, [15:8]=8'h0A, o_unsupported=0; REQ high exactly 10 times.
REQ-032 Opcode 8'h12 plus five bytes -> o_cmd_len=6, o_unsupported=1; opcode 8'hC0 -> o_cmd_len=10, o_unsupported=1.
REQ-033 i_abort=1 after third byte ACK -> o_req=0 and IDLE next cycle, o_cmd_valid never asserts; fresh i_start then receives full command.
REQ-034 With TIMEOUT_CYCLES=16 and i_ack held 0 in REQ_HI -> o_timeout pulses once 16 cycles after REQ_HI entry, then o_busy=0.
REQ-035 i_start while DONE -> no effect, o_cmd_valid stays 1; i_cmd_taken -> o_cmd_valid=0 next cycle; i_rst mid-command -> all outputs at reset values next cycle.
